// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [1:0]  INSTR_ALIGN  = 2'b00;

    // Force a redirect target onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], INSTR_ALIGN};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_i,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;

    // Count up on inc_i until saturated; synchronous clear.
    always_ff @(posedge clk) begin
        if (reset)                      cnt_q <= '0;
        else if (inc_i && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch-stage PC owner: sequential fetch, delayed-branch redirects with a
// one-entry target buffer when memory is not ready, and perf counters.
module fetch_pc_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter int          CW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          branch,
    input  logic [31:0]   npc,
    input  logic          im_ready,
    output logic          im_req,
    output logic [31:0]   im_addr,
    output logic          f_valid,
    output logic [31:0]   f_pc,
    output logic [31:0]   f_pc4,
    output logic          redir_err,
    output logic [CW-1:0] cnt_stall,
    output logic [CW-1:0] cnt_redir
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_q, pend_d;
    logic         redir_err_q, redir_err_d;
    logic         accept;
    logic [31:0]  tgt;

    assign tgt = align_pc(npc);

    // State, PC, buffered target and error flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= PC_RESET;
            pend_q      <= '0;
            redir_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            redir_err_q <= redir_err_d;
        end
    end

    // Next-state, PC sequencing and fetch handshake outputs.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_d      = pend_q;
        redir_err_d = 1'b0;
        accept      = 1'b0;
        im_req      = 1'b0;
        f_valid     = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                im_req  = 1'b1;
                f_valid = im_ready & ~stall;
                // D-stage operands are not trustworthy while stalled.
                accept  = branch & ~stall;
                if (accept) begin
                    redir_err_d = (npc[1:0] != INSTR_ALIGN);
                    if (im_ready) begin
                        // Delay slot completes this cycle; target goes next.
                        pc_d = tgt;
                    end else begin
                        // Delay slot still outstanding; park the target.
                        pend_d  = tgt;
                        state_d = PEND;
                    end
                end else if (f_valid) begin
                    pc_d = pc_q + 32'd4;
                end
            end
            PEND: begin
                im_req  = 1'b1;
                f_valid = im_ready & ~stall;
                if (f_valid) begin
                    pc_d    = pend_q;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign im_addr   = pc_q;
    assign f_pc      = pc_q;
    assign f_pc4     = pc_q + 32'd4;
    assign redir_err = redir_err_q;

    sat_counter #(.CW(CW)) u_cnt_stall (
        .clk   (clk),
        .reset (reset),
        .inc_i (stall && (state_q != BOOT)),
        .cnt_o (cnt_stall)
    );

    sat_counter #(.CW(CW)) u_cnt_redir (
        .clk   (clk),
        .reset (reset),
        .inc_i (accept),
        .cnt_o (cnt_redir)
    );

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_pc_sequencer;

    localparam int          CW   = 5;
    localparam logic [31:0] PCR  = 32'h0000_3000;
    localparam int          MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset, stall, branch, im_ready;
    logic [31:0]   npc;
    logic          im_req, f_valid, redir_err;
    logic [31:0]   im_addr, f_pc, f_pc4;
    logic [CW-1:0] cnt_stall, cnt_redir;

    int nvec = 0;
    int nerr = 0;

    // Reference model: boot flag, PC, a queue of parked targets, counters.
    bit          m_boot;
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    bit          m_err;
    int          m_cs, m_cr;

    fetch_pc_sequencer #(.PC_RESET(PCR), .CW(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .npc(npc),
        .im_ready(im_ready), .im_req(im_req), .im_addr(im_addr),
        .f_valid(f_valid), .f_pc(f_pc), .f_pc4(f_pc4), .redir_err(redir_err),
        .cnt_stall(cnt_stall), .cnt_redir(cnt_redir)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit fv, acc;
        if (reset) begin
            m_boot = 1; m_pc = PCR; m_pend.delete(); m_err = 0; m_cs = 0; m_cr = 0;
        end else if (m_boot) begin
            m_boot = 0; m_err = 0;
        end else begin
            fv  = im_ready && !stall;
            acc = (m_pend.size() == 0) && branch && !stall;
            m_err = acc && (npc[1:0] != 2'b00);
            if (stall && m_cs < MAXC) m_cs++;
            if (acc && m_cr < MAXC)   m_cr++;
            if (m_pend.size() > 0) begin
                if (fv) m_pc = m_pend.pop_front();
            end else if (acc) begin
                if (im_ready) m_pc = npc & 32'hFFFF_FFFC;
                else          m_pend.push_back(npc & 32'hFFFF_FFFC);
            end else if (fv) begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic b,
                         input logic [31:0] n, input logic rdy);
        reset = r; stall = s; branch = b; npc = n; im_ready = rdy;
    endtask

    // Reset, pass BOOT, then take k sequential fetches.
    task automatic reset_and_fetch(input int k);
        drive(1, 0, 0, 32'h0, 1);
        tick(); tick();
        drive(0, 0, 0, 32'h0, 1);
        tick();
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic test_reset();
        reset_and_fetch(0);
        // reset_and_fetch already left BOOT; redo to look at BOOT itself
        drive(1, 0, 0, 32'h0, 1);
        tick(); tick();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        nvec++; if (im_req !== 1'b0)  begin nerr++; $display("FAIL reset_im_req got %0b exp 0", im_req); end
        nvec++; if (f_valid !== 1'b0) begin nerr++; $display("FAIL reset_f_valid got %0b exp 0", f_valid); end
        nvec++; if (f_pc !== PCR)     begin nerr++; $display("FAIL reset_pc got %h exp %h", f_pc, PCR); end
        nvec++; if (cnt_stall !== '0 || cnt_redir !== '0 || redir_err !== 1'b0) begin
            nerr++; $display("FAIL reset_cnt got %0d/%0d/%0b exp 0/0/0", cnt_stall, cnt_redir, redir_err);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nvec++; if (f_pc !== PCR + 32'(4 * i) || f_valid !== 1'b1) begin
                nerr++; $display("FAIL seq_fetch%0d got pc %h v %0b exp pc %h v 1", i, f_pc, f_valid, PCR + 32'(4 * i));
            end
            tick();
        end
    endtask

    task automatic test_redirect_ready();
        reset_and_fetch(2);
        drive(0, 0, 1, 32'h3100, 1);
        @(negedge clk);
        nvec++; if (f_pc !== 32'h3008 || f_valid !== 1'b1) begin
            nerr++; $display("FAIL rdy_slot got pc %h v %0b exp 3008 v 1", f_pc, f_valid);
        end
        tick();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        nvec++; if (f_pc !== 32'h3100) begin nerr++; $display("FAIL rdy_tgt got %h exp 3100", f_pc); end
        nvec++; if (cnt_redir !== CW'(1) || redir_err !== 1'b0) begin
            nerr++; $display("FAIL rdy_cnt got %0d err %0b exp 1 err 0", cnt_redir, redir_err);
        end
        tick();
    endtask

    task automatic test_redirect_pend();
        reset_and_fetch(2);
        drive(0, 0, 1, 32'h3100, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            nvec++; if (f_pc !== 32'h3008 || f_valid !== 1'b0 || im_req !== 1'b1) begin
                nerr++; $display("FAIL pend_hold%0d got pc %h v %0b req %0b exp 3008 0 1", i, f_pc, f_valid, im_req);
            end
            tick();
            drive(0, 0, 0, 32'h0, 0);
        end
        drive(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        nvec++; if (f_pc !== 32'h3008 || f_valid !== 1'b1) begin
            nerr++; $display("FAIL pend_slot got pc %h v %0b exp 3008 v 1", f_pc, f_valid);
        end
        tick();
        @(negedge clk);
        nvec++; if (f_pc !== 32'h3100) begin nerr++; $display("FAIL pend_tgt got %h exp 3100", f_pc); end
        tick();
    endtask

    task automatic test_stall_branch();
        reset_and_fetch(4);
        drive(0, 1, 1, 32'h3200, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            nvec++; if (f_pc !== 32'h3010 || f_valid !== 1'b0) begin
                nerr++; $display("FAIL stall_hold%0d got pc %h v %0b exp 3010 v 0", i, f_pc, f_valid);
            end
            tick();
        end
        drive(0, 0, 1, 32'h3200, 1);
        @(negedge clk);
        nvec++; if (cnt_stall !== CW'(3) || cnt_redir !== '0) begin
            nerr++; $display("FAIL stall_cnt got %0d/%0d exp 3/0", cnt_stall, cnt_redir);
        end
        tick();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        nvec++; if (f_pc !== 32'h3200) begin nerr++; $display("FAIL stall_tgt got %h exp 3200", f_pc); end
        tick();
    endtask

    task automatic test_misaligned();
        reset_and_fetch(1);
        drive(0, 0, 1, 32'h3203, 1);
        tick();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        nvec++; if (f_pc !== 32'h3200 || redir_err !== 1'b1) begin
            nerr++; $display("FAIL misal_first got pc %h err %0b exp 3200 err 1", f_pc, redir_err);
        end
        tick();
        @(negedge clk);
        nvec++; if (redir_err !== 1'b0) begin nerr++; $display("FAIL misal_pulse got %0b exp 0", redir_err); end
        tick();
    endtask

    task automatic test_reset_in_pend();
        reset_and_fetch(2);
        drive(0, 0, 1, 32'h3100, 0);
        tick();
        drive(0, 1, 0, 32'h0, 0);
        tick();
        drive(0, 0, 0, 32'h0, 0);
        @(negedge clk);
        nvec++; if (cnt_stall !== CW'(1) || cnt_redir !== CW'(1)) begin
            nerr++; $display("FAIL rpend_pre got %0d/%0d exp 1/1", cnt_stall, cnt_redir);
        end
        drive(1, 0, 0, 32'h0, 1);
        tick();
        drive(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        nvec++; if (im_req !== 1'b0 || f_pc !== PCR || cnt_stall !== '0 || cnt_redir !== '0) begin
            nerr++; $display("FAIL rpend_boot got req %0b pc %h cnt %0d/%0d exp 0 %h 0/0", im_req, f_pc, cnt_stall, cnt_redir, PCR);
        end
        tick();
        @(negedge clk);
        nvec++; if (f_pc !== PCR || f_valid !== 1'b1) begin
            nerr++; $display("FAIL rpend_first got %h v %0b exp %h v 1", f_pc, f_valid, PCR);
        end
        tick();
        @(negedge clk);
        nvec++; if (f_pc !== PCR + 32'd4) begin nerr++; $display("FAIL rpend_discard got %h exp %h", f_pc, PCR + 32'd4); end
        tick();
    endtask

    task automatic test_saturation();
        reset_and_fetch(0);
        drive(0, 1, 0, 32'h0, 1);
        for (int i = 0; i < MAXC + 5; i++) tick();
        @(negedge clk);
        nvec++; if (cnt_stall !== CW'(MAXC)) begin nerr++; $display("FAIL sat_stall got %0d exp %0d", cnt_stall, MAXC); end
        drive(0, 0, 1, 32'h4000, 1);
        for (int i = 0; i < MAXC + 5; i++) tick();
        @(negedge clk);
        nvec++; if (cnt_redir !== CW'(MAXC)) begin nerr++; $display("FAIL sat_redir got %0d exp %0d", cnt_redir, MAXC); end
        tick();
    endtask

    task automatic test_random();
        logic [CW-1:0] ecs, ecr;
        bit ereq, efv;
        reset_and_fetch(0);
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) < 3), $urandom(), ($urandom_range(0, 9) < 7));
            @(negedge clk);
            ereq = !m_boot;
            efv  = !m_boot && im_ready && !stall;
            ecs  = CW'(m_cs);
            ecr  = CW'(m_cr);
            nvec++; if (im_req !== ereq || f_valid !== efv) begin
                nerr++; $display("FAIL rnd_hs@%0d got req %0b v %0b exp %0b %0b", i, im_req, f_valid, ereq, efv);
            end
            if (!m_boot) begin
                nvec++; if (f_pc !== m_pc || im_addr !== m_pc || f_pc4 !== m_pc + 32'd4) begin
                    nerr++; $display("FAIL rnd_pc@%0d got %h/%h/%h exp pc %h", i, f_pc, im_addr, f_pc4, m_pc);
                end
            end
            nvec++; if (redir_err !== m_err) begin
                nerr++; $display("FAIL rnd_err@%0d got %0b exp %0b", i, redir_err, m_err);
            end
            nvec++; if (cnt_stall !== ecs || cnt_redir !== ecr) begin
                nerr++; $display("FAIL rnd_cnt@%0d got %0d/%0d exp %0d/%0d", i, cnt_stall, cnt_redir, ecs, ecr);
            end
            tick();
        end
    endtask

    initial begin
        drive(1, 0, 0, 32'h0, 0);
        test_reset();
        test_redirect_ready();
        test_redirect_pend();
        test_stall_branch();
        test_misaligned();
        test_reset_in_pend();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Owns the fetch-stage PC register of the 5-stage MIPS pipeline and sequences it.
- Inputs: redirect requests from the D-stage next-PC logic, stall from the hazard unit, and ready from instruction memory.
- Implements delayed-branch semantics: the delay slot is always fetched before the target.
- If memory is not ready when a redirect arrives, the target is buffered until the delay slot has been fetched.
- Provides saturating stall and redirect performance counters.

Parameters:
PC_RESET, 32'h0000_3000, PC value loaded on reset
CW, 32, width of each performance counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard unit freeze of F and D stages
branch  input  1  D-stage redirect request (jr/beq-taken/j/jal)
npc  input  32  redirect target, valid when branch=1
im_ready  input  1  instruction memory returns word for im_addr this cycle
im_req  output  1  fetch request
im_addr  output  32  fetch address (= current PC)
f_valid  output  1  fetched word is written into IF/ID this edge
f_pc  output  32  PC of the word being fetched
f_pc4  output  32  f_pc + 4 (link value source)
redir_err  output  1  one-cycle pulse: accepted target was misaligned
cnt_stall  output  CW  cycles with stall=1 outside BOOT, saturating
cnt_redir  output  CW  accepted redirects, saturating

Behaviour:
- State machine: BOOT, RUN, PEND. Reset -> BOOT.
- Reset values: pc=PC_RESET, pend=0, redir_err=0, both counters=0.
- Reset values of combinational outputs in BOOT: im_req=0, f_valid=0.
- Reset has priority over every other event and discards any pending target.
- BOOT: im_req=0, f_valid=0. Unconditional transition to RUN next cycle; pc unchanged.
- RUN and PEND:
  - im_req=1, im_addr=f_pc=pc, f_pc4=pc+4 (32-bit wrap-around, no carry out).
  - f_valid = im_ready & ~stall, combinational, zero latency.
- Redirect is accepted only when state==RUN & branch & ~stall.
  - branch is ignored while stall=1, because D-stage operands are not yet valid.
  - branch is ignored in PEND and BOOT.
- Target alignment: tgt = {npc[31:2],2'b00}.
  - redir_err is registered: it is 1 in the cycle after an accepted redirect whose npc[1:0]!=0, and 0 otherwise.
- RUN next-state and pc update:
  - Accepted redirect & im_ready: pc<=tgt, stay RUN. The delay slot is fetched this cycle.
  - Accepted redirect & ~im_ready: pend<=tgt, pc holds, go to PEND.
  - No redirect & f_valid: pc<=pc+4.
  - Otherwise: pc holds.
- PEND:
  - f_valid: pc<=pend, go to RUN.
  - Otherwise: hold pc and pend.
  - stall in PEND also holds.
- Simultaneous stall & branch & ~im_ready: no acceptance, pc holds, stay RUN.
- cnt_stall increments when stall=1 & state!=BOOT.
- cnt_redir increments on each accepted redirect.
- Both counters saturate at all-ones and never wrap.

Decomposition:
- Package fetch_pkg holds:
  - state enum {BOOT, RUN, PEND};
  - PC_RESET default constant;
  - instruction-alignment constant (2'b00).
- One sub-module, sat_counter (width CW, inc input, synchronous reset), instantiated twice for the performance counters.

Test Plan:
1. Reset, then im_ready=1, stall=0 for 4 cycles:
   - im_req=0 in the cycle after reset;
   - then f_pc = 3000, 3004, 3008, 300C, with f_valid=1 each cycle.
2. f_pc=3008, branch=1, npc=3100, im_ready=1:
   - f_valid=1 for 3008 (the delay slot);
   - next f_pc=3100; cnt_redir=1; redir_err stays 0.
3. f_pc=3008, branch=1, npc=3100, im_ready=0 for 2 cycles then 1:
   - state goes to PEND; f_pc holds 3008 and f_valid=0 while im_ready=0;
   - f_valid=1 for 3008 when im_ready rises;
   - next f_pc=3100.
4. stall=1 for 3 cycles with branch=1, npc=3200, at f_pc=3010:
   - f_pc holds 3010, f_valid=0, cnt_stall=3, cnt_redir unchanged;
   - after stall drops with branch=1, next f_pc=3200.
5. Accepted redirect with npc=3203:
   - next f_pc=3200;
   - redir_err=1 for exactly one cycle after acceptance.
6. Reset asserted while in PEND with pend=3100:
   - next state BOOT, pc=3000, pend discarded, counters=0;
   - first fetch after BOOT is 3000.
